// File: rtl/led_pattern_gen.sv
// LED pattern engine: chase, bounce, binary count and PWM breathe on an LED bank,
// stepped by a clock divider that can be frozen with pause.
module led_pattern_gen #(
  parameter int unsigned CLK_HZ     = 27000000,
  parameter int unsigned STEP_HZ    = 8,
  parameter int unsigned NUM_LEDS   = 6,
  parameter int unsigned PWM_BITS   = 8,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic                pause,
  output logic [NUM_LEDS-1:0] led,
  output logic                step,
  output logic [1:0]          mode_q
);

  localparam int unsigned StepDiv = CLK_HZ / STEP_HZ;
  localparam int unsigned DivW    = $clog2(StepDiv);
  localparam int unsigned PosW    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [DivW-1:0]     DivMax   = DivW'(StepDiv - 1);
  localparam logic [PosW-1:0]     PosMax   = PosW'(NUM_LEDS - 1);
  localparam logic [PWM_BITS-1:0] LevelMax = '1;
  localparam logic [NUM_LEDS-1:0] LedOff   = ACTIVE_LOW ? '1 : '0;

  typedef enum logic [1:0] {
    ModeChase   = 2'd0,
    ModeBounce  = 2'd1,
    ModeCount   = 2'd2,
    ModeBreathe = 2'd3
  } mode_e;

  logic [DivW-1:0]     div_q, div_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PosW-1:0]     pos_q, pos_d;
  logic                pos_up_q, pos_up_d;
  logic [NUM_LEDS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic                lvl_up_q, lvl_up_d;
  logic                tick_q, tick_d;
  logic [1:0]          mode_d;
  logic [NUM_LEDS-1:0] led_d;
  logic                step_d;
  logic                tick;
  logic [NUM_LEDS-1:0] pattern;

  always_comb begin
    tick     = (div_q == DivMax) && !pause;
    div_d    = div_q;
    pwm_d    = pwm_q + PWM_BITS'(1);
    pos_d    = pos_q;
    pos_up_d = pos_up_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    lvl_up_d = lvl_up_q;
    mode_d   = mode_q;
    tick_d   = tick;

    if (!pause) begin
      div_d = (div_q == DivMax) ? '0 : div_q + DivW'(1);
    end

    if (tick) begin
      if (mode != mode_q) begin
        // A mode switch only reloads state; the first advance happens on the next tick.
        mode_d   = mode;
        pos_d    = '0;
        pos_up_d = 1'b1;
        cnt_d    = '0;
        level_d  = '0;
        lvl_up_d = 1'b1;
      end else begin
        unique case (mode_e'(mode_q))
          ModeChase: begin
            pos_d = (pos_q == PosMax) ? '0 : pos_q + PosW'(1);
          end
          ModeBounce: begin
            if (NUM_LEDS > 1) begin
              if (pos_up_q) begin
                pos_d = pos_q + PosW'(1);
                if (pos_d == PosMax) pos_up_d = 1'b0;
              end else begin
                pos_d = pos_q - PosW'(1);
                if (pos_d == '0) pos_up_d = 1'b1;
              end
            end
          end
          ModeCount: begin
            cnt_d = cnt_q + NUM_LEDS'(1);
          end
          ModeBreathe: begin
            if (lvl_up_q) begin
              level_d = level_q + PWM_BITS'(1);
              if (level_d == LevelMax) lvl_up_d = 1'b0;
            end else begin
              level_d = level_q - PWM_BITS'(1);
              if (level_d == '0) lvl_up_d = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    pattern = '0;
    unique case (mode_e'(mode_q))
      ModeChase, ModeBounce: pattern = NUM_LEDS'(1) << pos_q;
      ModeCount:             pattern = cnt_q;
      ModeBreathe:           pattern = (pwm_q < level_q) ? '1 : '0;
    endcase
    led_d  = ACTIVE_LOW ? ~pattern : pattern;
    // Delayed by one so the pulse lines up with the first cycle of the new led value.
    step_d = tick_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q    <= '0;
      pwm_q    <= '0;
      pos_q    <= '0;
      pos_up_q <= 1'b1;
      cnt_q    <= '0;
      level_q  <= '0;
      lvl_up_q <= 1'b1;
      tick_q   <= 1'b0;
      mode_q   <= 2'd0;
      led      <= LedOff;
      step     <= 1'b0;
    end else begin
      div_q    <= div_d;
      pwm_q    <= pwm_d;
      pos_q    <= pos_d;
      pos_up_q <= pos_up_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      lvl_up_q <= lvl_up_d;
      tick_q   <= tick_d;
      mode_q   <= mode_d;
      led      <= led_d;
      step     <= step_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with a scoreboard of expected led values (or breathe
// duty counts) consumed at each step pulse.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       pause = 1'b0;
  logic [5:0] led;
  logic       step;
  logic [1:0] mode_q;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q[$];

  led_pattern_gen #(
    .CLK_HZ    (40),
    .STEP_HZ   (10),
    .NUM_LEDS  (6),
    .PWM_BITS  (3),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .pause (pause),
    .led   (led),
    .step  (step),
    .mode_q(mode_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] dot(input int p);
    logic [5:0] one;
    one = 6'd1;
    return ~(one << p);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_step(input string tag, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!step && cycles < 40);
    if (!step) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_timeout: observed no step expected step within 40 cycles", tag);
    end
  endtask

  function automatic logic [31:0] pop_exp(input string tag);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
      return 32'hdead;
    end
    return exp_q.pop_front();
  endfunction

  task automatic sb_step(input string tag, output int cycles);
    wait_step(tag, cycles);
    chk(tag, {26'd0, led}, pop_exp(tag));
  endtask

  // Freeze the divider and count lit cycles over one full PWM period.
  task automatic sb_duty(input string tag);
    int on;
    int other;
    int c;
    wait_step(tag, c);
    pause = 1'b1;
    on    = 0;
    other = 0;
    repeat (8) begin
      @(negedge clk);
      if (led === 6'h00) on++;
      else if (led !== 6'h3f) other++;
    end
    pause = 1'b0;
    chk({tag, "_on"}, on, pop_exp(tag));
    chk({tag, "_other"}, other, 0);
  endtask

  initial begin
    int c;
    int bseq[16];
    int lseq[15];
    bseq = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 4};
    lseq = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

    // Reset and chase
    cyc(3);
    chk("rst_led", led, 6'h3f);
    chk("rst_step", step, 0);
    chk("rst_mode_q", mode_q, 0);
    rst_n = 1'b1;
    cyc(1);
    chk("rel_led", led, 6'b111110);
    for (int p = 1; p <= 6; p++) exp_q.push_back(dot(p % 6));
    for (int i = 0; i < 6; i++) begin
      sb_step("chase", c);
      chk("chase_gap", c, 4);
    end

    // Pause for 10 cycles with a mode toggle inside
    pause = 1'b1;
    mode  = 2'd3;
    cyc(5);
    mode = 2'd0;
    cyc(5);
    chk("pause_led", led, dot(0));
    chk("pause_step", step, 0);
    chk("pause_mode_q", mode_q, 0);
    pause = 1'b0;
    exp_q.push_back(dot(1));
    sb_step("pause_resume", c);
    chk("pause_gap", 10 + c, 14);

    // Bounce from reset
    rst_n = 1'b0;
    mode  = 2'd1;
    cyc(2);
    chk("rst2_led", led, 6'h3f);
    chk("rst2_step", step, 0);
    rst_n = 1'b1;
    cyc(1);
    chk("rel2_led", led, dot(0));
    exp_q.push_back(dot(0));
    sb_step("bounce_switch", c);
    chk("bounce_mode_q", mode_q, 1);
    foreach (bseq[i]) exp_q.push_back(dot(bseq[i]));
    foreach (bseq[i]) sb_step("bounce", c);

    // Reset on the tick edge while at pos 4 heading down
    cyc(2);
    rst_n = 1'b0;
    mode  = 2'd0;
    cyc(1);
    chk("midrst_led", led, 6'h3f);
    chk("midrst_step", step, 0);
    chk("midrst_mode_q", mode_q, 0);
    rst_n = 1'b1;
    cyc(1);
    chk("midrst_rel_led", led, dot(0));
    chk("midrst_rel_step", step, 0);

    // Count with wrap
    mode = 2'd2;
    exp_q.push_back(32'h3f);
    sb_step("count_switch", c);
    chk("count_mode_q", mode_q, 2);
    for (int k = 1; k <= 64; k++) begin
      logic [5:0] kv;
      kv = 6'(k);
      exp_q.push_back({26'd0, ~kv});
      sb_step("count", c);
    end

    // Breathe ramp, duty measured per level
    mode = 2'd3;
    exp_q.push_back(0);
    sb_duty("breathe_l0");
    chk("breathe_mode_q", mode_q, 3);
    foreach (lseq[i]) begin
      exp_q.push_back(lseq[i]);
      sb_duty("breathe");
    end

    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern engine for the board's active-low LED bank, driven directly by the 27 MHz board clock. Generates one of four runtime-selectable patterns: chase, bounce, binary count and PWM breathe. Step rate is derived from a clock divider and can be frozen with a pause input. The block sits between the board clock and the `led` pins and replaces fixed single-pattern chasers.

## Interface
- `CLK_HZ`, 27000000: input clock frequency.
- `STEP_HZ`, 8: pattern steps per second; `STEP_DIV = CLK_HZ/STEP_HZ`, must be ≥ 2.
- `NUM_LEDS`, 6: LED count, ≥ 1.
- `PWM_BITS`, 8: breathe brightness/PWM resolution, ≥ 2.
- `ACTIVE_LOW`, 1: 1 = `led` driven inverted (board LEDs on when low).
- `clk  in  1`: board clock; all logic on rising edge.
- `rst_n  in  1`: synchronous, active-low reset.
- `mode  in  2`: 0 chase, 1 bounce, 2 count, 3 breathe; sampled only on step ticks.
- `pause  in  1`: 1 freezes the step divider and pattern state.
- `led  out  NUM_LEDS`: registered LED drive, polarity per `ACTIVE_LOW`.
- `step  out  1`: one-cycle pulse, high in the first cycle `led` shows a new step.
- `mode_q  out  2`: currently active mode.

## Operation
- Divider `div_cnt` counts 0..STEP_DIV-1 and wraps. `tick` = (div_cnt == STEP_DIV-1) and !pause. While pause=1, div_cnt holds.
- On tick, `mode` is compared with `mode_q`:
  - Different: mode_q <= mode; pattern state is reinitialised (pos=0, dir=up, count=0, level=0, breathe dir=up) and does not advance on this tick.
  - Same: state advances per mode_q.
- Chase: pos <= (pos==NUM_LEDS-1) ? 0 : pos+1. Pattern = one-hot bit pos.
- Bounce: pos moves ±1 per dir. dir flips to down when pos reaches NUM_LEDS-1 and to up at 0; endpoints are not repeated (N=6: 0,1,2,3,4,5,4,3,2,1,0,1…). NUM_LEDS=1: pos stays 0. Pattern = one-hot bit pos.
- Count: count <= count+1, mod 2^NUM_LEDS. Pattern = count.
- Breathe: level ramps 0→2^PWM_BITS-1→0 by 1 per tick, endpoints not repeated. `pwm_cnt` (PWM_BITS wide) increments every clk, including while paused. Pattern = all ones when pwm_cnt < level, else all zeros. Level 0 = fully off.
- Pattern state is held in every mode; a register unused by the current mode keeps its value until a mode-change reinit.
- led <= ACTIVE_LOW ? ~pattern : pattern.

## Timing
- Reset (rst_n low at an edge): div_cnt=0, pwm_cnt=0, mode_q=0, pos=0, dir=up, count=0, level=0, step=0, internal tick delay=0. `led` = all off (all ones if ACTIVE_LOW, else zeros). Reset wins over pause and tick.
- First edge after reset release: `led` shows chase pos 0 (ACTIVE_LOW, N=6: 6'b111110).
- State updates on the edge where tick=1 (edge E). `led` reflects the new state at E+1. `step` is high for exactly the cycle after E+1, aligned with the new `led`.
- Step period = STEP_DIV cycles with pause low. Pause held for k cycles stretches that period by exactly k.
- `mode` changes between ticks have no effect. Only the value present on the tick cycle is used.
- Breathe output: `led` lags pwm_cnt/level by one cycle.
- Reset mid-step, mid-bounce or mid-breathe discards all state with no partial step and no `step` pulse.

## Test plan
All scenarios use CLK_HZ=40, STEP_HZ=10 (STEP_DIV=4), NUM_LEDS=6, PWM_BITS=3, ACTIVE_LOW=1.
- Reset then chase, mode=0: `led` 111110 after release, then 111101, 111011…011111, 111110. Each change 4 cycles apart and coincident with a 1-cycle `step`.
- Bounce, mode=1 from reset: the first tick only switches mode (`led` stays 111110, mode_q=1). Then pos sequence 1,2,3,4,5,4,3,2,1,0,1 with no repeated endpoints.
- Count, mode=2: after the mode-switch tick, `led` = ~count for 0,1,2,…,63,0. Wrap verified after 64 steps.
- Breathe, mode=3: level follows 0..7..0. At level 3, exactly 3 of every 8 cycles have `led`=000000, the rest 111111. At level 0, `led` stays 111111.
- Pause: assert pause for 10 cycles mid-chase. The next `step` arrives exactly 14 cycles after the previous one. Toggle `mode` during pause: no change.
- Reset mid-operation: rst_n low for 1 cycle during bounce pos=4 dir=down. Next cycle: mode_q=0, `led`=111111 then 111110. No `step` pulse is emitted during reset.
